// File: rtl/adc_idelay_tap_calibrator_if.sv
// Control/data bundle between the ADC capture fabric and the IDELAY tap calibrator.
// The calibrator sits on the slave side. The capture path and control registers sit on the master side.
interface adc_idelay_tap_calibrator_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TAP_WIDTH  = 5
);
  logic                  idelay_rdy;
  logic                  cal_start;
  logic [DATA_WIDTH-1:0] adc_data;
  logic [TAP_WIDTH-1:0]  tap_value;
  logic                  tap_load;
  logic                  cal_busy;
  logic                  cal_done;
  logic                  cal_error;
  logic [TAP_WIDTH:0]    eye_width;

  modport master (
    output idelay_rdy, cal_start, adc_data,
    input  tap_value, tap_load, cal_busy, cal_done, cal_error, eye_width
  );

  modport slave (
    input  idelay_rdy, cal_start, adc_data,
    output tap_value, tap_load, cal_busy, cal_done, cal_error, eye_width
  );
endinterface

// File: rtl/adc_idelay_tap_calibrator.sv
// IDELAY tap calibrator for the ADC data eye.
// The block sweeps every tap and checks the captured words against the training pattern.
// It then loads the centre of the longest passing window into the IDELAYs.
// All logic runs on the rising edge of sys_clk. Reset is synchronous and active low.
module adc_idelay_tap_calibrator #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    TAP_WIDTH     = 5,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 8'hA5,
  parameter int                    SETTLE_CYCLES = 16,
  parameter int                    SAMPLE_CYCLES = 64
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  adc_idelay_tap_calibrator_if.slave    cal
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_LOAD, S_SETTLE, S_CHECK,
    S_NEXT, S_CENTER, S_FINAL, S_DONE, S_FAIL
  } state_t;

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [TAP_WIDTH-1:0] TAP_MAX     = '1;

  state_t               state;
  logic [TAP_WIDTH-1:0] cur_tap;
  logic [TAP_WIDTH-1:0] run_start;
  logic [TAP_WIDTH:0]   run_len;
  logic [TAP_WIDTH-1:0] best_start;
  logic [TAP_WIDTH:0]   best_len;
  logic [CNT_W-1:0]     cnt;
  logic                 tap_fail;

  logic [TAP_WIDTH:0]   run_len_inc;
  logic [TAP_WIDTH-1:0] run_start_eff;
  logic [TAP_WIDTH-1:0] final_tap;
  logic                 rdy_lost;
  logic                 word_bad;

  // Window bookkeeping and abort detection, evaluated ahead of the state register.
  assign run_len_inc   = run_len + 1'b1;
  assign run_start_eff = (run_len == '0) ? cur_tap : run_start;
  // best_start + best_len/2 never exceeds the last tap, so dropping the carry is exact.
  assign final_tap     = best_start + TAP_WIDTH'(best_len >> 1);
  assign word_bad      = (cal.adc_data != TRAIN_PATTERN);
  assign rdy_lost      = !cal.idelay_rdy &&
                         (state inside {S_LOAD, S_SETTLE, S_CHECK, S_NEXT, S_CENTER, S_FINAL});

  // Calibration sequencer with registered outputs. An IDELAYCTRL ready drop restarts the sweep.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state          <= S_IDLE;
      cur_tap        <= '0;
      run_start      <= '0;
      run_len        <= '0;
      best_start     <= '0;
      best_len       <= '0;
      cnt            <= '0;
      tap_fail       <= 1'b0;
      cal.tap_value  <= '0;
      cal.tap_load   <= 1'b0;
      cal.cal_busy   <= 1'b0;
      cal.cal_done   <= 1'b0;
      cal.cal_error  <= 1'b0;
      cal.eye_width  <= '0;
    end else begin
      // NOTE: every register here is non-blocking, so the branches below all read pre-edge values;
      // the strobe defaults low and a branch raises it for exactly one cycle.
      cal.tap_load <= 1'b0;
      if (rdy_lost) begin
        state      <= S_WAIT_RDY;
        cur_tap    <= '0;
        run_start  <= '0;
        run_len    <= '0;
        best_start <= '0;
        best_len   <= '0;
        cnt        <= '0;
        tap_fail   <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_FAIL: begin
            if (cal.cal_start) begin
              state         <= S_WAIT_RDY;
              cal.cal_busy  <= 1'b1;
              cal.cal_done  <= 1'b0;
              cal.cal_error <= 1'b0;
              cal.eye_width <= '0;
              cur_tap       <= '0;
              run_start     <= '0;
              run_len       <= '0;
              best_start    <= '0;
              best_len      <= '0;
              cnt           <= '0;
              tap_fail      <= 1'b0;
            end
          end
          S_WAIT_RDY: begin
            if (cal.idelay_rdy) begin
              state         <= S_LOAD;
              cal.tap_value <= cur_tap;
              cal.tap_load  <= 1'b1;
            end
          end
          S_LOAD: begin
            state    <= S_SETTLE;
            cnt      <= '0;
            tap_fail <= 1'b0;
          end
          S_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt   <= '0;
              state <= S_CHECK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_CHECK: begin
            if (word_bad) tap_fail <= 1'b1;
            if (cnt == SAMPLE_LAST) begin
              cnt   <= '0;
              state <= S_NEXT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_NEXT: begin
            if (!tap_fail) begin
              run_len   <= run_len_inc;
              run_start <= run_start_eff;
              if (run_len_inc > best_len) begin
                best_len   <= run_len_inc;
                best_start <= run_start_eff;
              end
            end else begin
              run_len <= '0;
            end
            if (cur_tap == TAP_MAX) begin
              state <= S_CENTER;
            end else begin
              cur_tap       <= cur_tap + 1'b1;
              cal.tap_value <= cur_tap + 1'b1;
              cal.tap_load  <= 1'b1;
              state         <= S_LOAD;
            end
          end
          S_CENTER: begin
            cal.tap_load <= 1'b1;
            if (best_len == '0) begin
              cal.tap_value <= '0;
              cal.cal_error <= 1'b1;
              cal.cal_busy  <= 1'b0;
              state         <= S_FAIL;
            end else begin
              cal.tap_value <= final_tap;
              cal.eye_width <= best_len;
              state         <= S_FINAL;
            end
          end
          S_FINAL: begin
            cal.cal_done <= 1'b1;
            cal.cal_busy <= 1'b0;
            state        <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_idelay_tap_calibrator.sv
// Self-checking bench for adc_idelay_tap_calibrator.
// A per-tap pass mask stands in for the data eye.
// A window-search model predicts the best window and the expected load sequence.
module tb_adc_idelay_tap_calibrator;
  localparam int DW      = 8;
  localparam int TW      = 5;
  localparam int NT      = 1 << TW;
  localparam int SETTLE  = 16;
  localparam int SAMPLE  = 64;
  localparam int TAP_GAP = 1 + SETTLE + SAMPLE + 1;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic [NT-1:0] pass_mask = '0;

  adc_idelay_tap_calibrator_if #(.DATA_WIDTH(DW), .TAP_WIDTH(TW)) cal_if ();

  adc_idelay_tap_calibrator #(
    .DATA_WIDTH(DW), .TAP_WIDTH(TW), .TRAIN_PATTERN(8'hA5),
    .SETTLE_CYCLES(SETTLE), .SAMPLE_CYCLES(SAMPLE)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .cal      (cal_if)
  );

  always #5 sys_clk = ~sys_clk;

  // The eye is modelled as a pattern word on passing taps and a corrupted word elsewhere.
  always_comb cal_if.adc_data = pass_mask[cal_if.tap_value] ? 8'hA5 : 8'h5A;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int exp_q[$];
  int last_load = -1;
  int n_loads   = 0;
  int m_best_len, m_best_start, m_final;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Longest all-pass window; scanning starts from the longest length and the lowest start, so the earliest window wins ties.
  function automatic void eye_model(input logic [NT-1:0] m, output int bs, output int bl);
    bs = 0;
    bl = 0;
    for (int len = NT; len >= 1 && bl == 0; len--) begin
      for (int s = 0; s + len <= NT && bl == 0; s++) begin
        bit ok = 1'b1;
        for (int k = s; k < s + len; k++) ok &= m[k];
        if (ok) begin
          bs = s;
          bl = len;
        end
      end
    end
  endfunction

  // Compare process: loads arrive in model order with fixed spacing, and done/error are never both set.
  always @(negedge sys_clk) begin
    check("done_err_exclusive", {63'd0, cal_if.cal_done & cal_if.cal_error}, 64'd0);
    if (cal_if.tap_load) begin
      n_loads++;
      check("load_expected", {63'd0, exp_q.size() > 0}, 64'd1);
      if (exp_q.size() > 0) begin
        int e;
        e = exp_q.pop_front();
        check("load_tap", cal_if.tap_value, e);
        if (last_load >= 0)
          check("load_gap", cyc - last_load, (exp_q.size() == 0) ? TAP_GAP + 1 : TAP_GAP);
        last_load = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic arm(input logic [NT-1:0] m);
    eye_model(m, m_best_start, m_best_len);
    m_final = (m_best_len == 0) ? 0 : m_best_start + m_best_len / 2;
    exp_q.delete();
    for (int t = 0; t < NT; t++) exp_q.push_back(t);
    exp_q.push_back(m_final);
    last_load = -1;
    n_loads   = 0;
    pass_mask = m;
  endtask

  task automatic pulse_start();
    cal_if.cal_start = 1'b1;
    @(negedge sys_clk);
    cal_if.cal_start = 1'b0;
  endtask

  task automatic wait_load(input int v, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge sys_clk);
      if (cal_if.tap_load && cal_if.tap_value == TW'(v)) ok = 1'b1;
    end
    check("wait_load_in_budget", {63'd0, ok}, 64'd1);
  endtask

  task automatic finish_run(input int eye, input int tap, input int err);
    bit ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge sys_clk);
      if (cal_if.cal_done || cal_if.cal_error) ok = 1'b1;
    end
    check("end_in_budget", {63'd0, ok}, 64'd1);
    tick(2);
    check("model_eye_pin", m_best_len, eye);
    check("model_tap_pin", m_final, tap);
    check("model_err_pin", {63'd0, m_best_len == 0}, err);
    check("eye_width", cal_if.eye_width, m_best_len);
    check("tap_value", cal_if.tap_value, m_final);
    check("cal_done", {63'd0, cal_if.cal_done}, {63'd0, m_best_len != 0});
    check("cal_error", {63'd0, cal_if.cal_error}, {63'd0, m_best_len == 0});
    check("cal_busy_end", {63'd0, cal_if.cal_busy}, 64'd0);
    check("load_count", n_loads, NT + 1);
    check("load_queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_cal(input logic [NT-1:0] m, input int eye, input int tap, input int err);
    arm(m);
    pulse_start();
    finish_run(eye, tap, err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tap_value"}, cal_if.tap_value, 0);
    check({tag, "_tap_load"}, {63'd0, cal_if.tap_load}, 0);
    check({tag, "_busy"}, {63'd0, cal_if.cal_busy}, 0);
    check({tag, "_done"}, {63'd0, cal_if.cal_done}, 0);
    check({tag, "_error"}, {63'd0, cal_if.cal_error}, 0);
    check({tag, "_eye"}, cal_if.eye_width, 0);
  endtask

  initial begin
    int loads_before;
    cal_if.idelay_rdy = 1'b1;
    cal_if.cal_start  = 1'b0;
    sys_rst_n         = 1'b0;
    tick(3);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    tick(2);

    // 1: every tap passes.
    run_cal(32'hFFFF_FFFF, 32, 16, 0);

    // 2: taps 10..19 pass; a cal_start mid-sweep must be ignored.
    arm(32'h000F_FC00);
    pulse_start();
    wait_load(3, 2000);
    tick(5);
    pulse_start();
    finish_run(10, 15, 0);

    // 3: windows 3..6 and 20..27, then equal windows 2..5 and 12..15.
    run_cal(32'h0FF0_0078, 8, 24, 0);
    run_cal(32'h0000_F03C, 4, 4, 0);

    // 4: no tap passes.
    run_cal(32'h0000_0000, 0, 0, 1);

    // 5: ready low at start, then dropped during the tap 7 check window.
    arm(32'h000F_FC00);
    cal_if.idelay_rdy = 1'b0;
    pulse_start();
    tick(20);
    check("wait_rdy_busy", {63'd0, cal_if.cal_busy}, 64'd1);
    check("wait_rdy_no_load", n_loads, 0);
    cal_if.idelay_rdy = 1'b1;
    wait_load(7, 2000);
    tick(1 + SETTLE + 10);
    cal_if.idelay_rdy = 1'b0;
    arm(32'h000F_FC00);
    tick(10);
    check("rdy_drop_busy", {63'd0, cal_if.cal_busy}, 64'd1);
    check("rdy_drop_no_load", n_loads, 0);
    cal_if.idelay_rdy = 1'b1;
    finish_run(10, 15, 0);

    // 6: reset during the settle of tap 12, then a fresh sweep.
    arm(32'h0FF0_0078);
    pulse_start();
    wait_load(12, 3000);
    tick(5);
    sys_rst_n = 1'b0;
    exp_q.delete();
    tick(1);
    check_all_zero("midreset");
    tick(3);
    sys_rst_n = 1'b1;
    loads_before = n_loads;
    tick(20);
    check("post_reset_no_load", n_loads, loads_before);
    check("post_reset_idle", {63'd0, cal_if.cal_busy}, 64'd0);
    run_cal(32'h0FF0_0078, 8, 24, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
